// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Loads hit combinationally; misses refill a whole line and stores write through word by word.
module dcache_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [DATA_WIDTH/8-1:0] cpu_be_i,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
    output logic [DATA_WIDTH-1:0]   cpu_rdata_o,
    output logic                    stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ack_i
);
    localparam int unsigned WordW = $clog2(WORDS_PER_LINE);
    localparam int unsigned IdxW  = $clog2(LINES);
    localparam int unsigned TagW  = ADDR_WIDTH - IdxW - WordW - 2;
    localparam int unsigned NumBe = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [WordW-1:0]      r_cnt;
    logic [LINES-1:0]      r_valid;
    logic [TagW-1:0]       r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES*WORDS_PER_LINE];

    logic [WordW-1:0]      w_word;
    logic [IdxW-1:0]       w_index;
    logic [TagW-1:0]       w_tag;
    logic                  w_hit;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_unused_offset;

    assign w_word          = cpu_addr_i[2 +: WordW];
    assign w_index         = cpu_addr_i[2+WordW +: IdxW];
    assign w_tag           = cpu_addr_i[ADDR_WIDTH-1 -: TagW];
    assign w_hit           = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_last          = (r_cnt == WordW'(WORDS_PER_LINE - 1));
    assign cpu_rdata_o     = r_data[{w_index, w_word}];
    assign w_unused_offset = ^cpu_addr_i[1:0];

    always_comb begin
        w_merged = r_data[{w_index, w_word}];
        for (int b = 0; b < NumBe; b++) begin
            if (cpu_be_i[b]) w_merged[8*b +: 8] = cpu_wdata_i[8*b +: 8];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (r_state)
            StIdle: begin
                if (cpu_req_i) begin
                    if (cpu_we_i) begin
                        stall_o     = 1'b1;
                        w_state_nxt = StWrite;
                    end else if (!w_hit) begin
                        stall_o     = 1'b1;
                        w_state_nxt = StRefill;
                    end
                end
            end
            StRefill: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_be_o   = '1;
                mem_addr_o = {w_tag, w_index, r_cnt, 2'b00};
                if (mem_ack_i && w_last) w_state_nxt = StIdle;
            end
            StWrite: begin
                // The pipeline advances in the ack cycle itself.
                stall_o     = !mem_ack_i;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_be_o    = cpu_be_i;
                mem_addr_o  = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata_o = cpu_wdata_i;
                if (mem_ack_i) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Invalidate up front so an aborted refill never leaves a half-filled valid line.
            if (r_state == StIdle && w_state_nxt == StRefill) begin
                r_valid[w_index] <= 1'b0;
                r_cnt            <= '0;
            end
            if (r_state == StRefill && mem_ack_i) begin
                r_cnt <= r_cnt + WordW'(1);
                if (w_last) r_valid[w_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == StRefill && mem_ack_i) begin
            r_data[{w_index, r_cnt}] <= mem_rdata_i;
            if (w_last) r_tag[w_index] <= w_tag;
        end
        if (!rst && r_state == StWrite && mem_ack_i && w_hit) begin
            r_data[{w_index, w_word}] <= w_merged;
        end
    end

endmodule
